arm_cpu: RTL and testbench

Multi-cycle 32-bit processor executing a subset of the ARM instruction set out of an internal byte-addressed RAM. It is the top of the processor design: it contains the control unit, register file, shifter/ALU datapath and program memory. The bench preloads program bytes into memory through hierarchy and observes state, registers and memory; the block has no data outputs.

---
 rtl/arm_cpu_pkg.sv | 54 +++++
 rtl/arm_alu.sv | 56 +++++
 rtl/arm_cpu.sv | 165 ++++++++++++++++
 tb/tb_arm_cpu.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_cpu_pkg.sv
// rtl/arm_cpu_pkg.sv - shared encodings and helpers for the arm_cpu core
package arm_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    LOAD_IR = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4
  } state_e;

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam logic [1:0] SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3;

  // Condition check against flags packed as {N, Z, C, V}; NV never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Rotate right; a zero amount returns the value unchanged.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
  endfunction

endpackage

// File: rtl/arm_alu.sv
// rtl/arm_alu.sv - 16-opcode data-processing ALU with NZCV generation
module arm_alu
  import arm_cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  input  logic        carry_i,
  input  logic        shift_carry_i,
  input  logic        overflow_i,
  output logic [31:0] result_o,
  output logic [3:0]  nzcv_o
);

  logic [31:0] x, y;
  logic        cin, arith;
  logic [32:0] sum;
  logic        ovf;

  // Map every arithmetic opcode onto one adder: x + y + cin
  always_comb begin
    x     = a_i;
    y     = b_i;
    cin   = 1'b0;
    arith = 1'b1;
    case (op_i)
      OP_SUB, OP_CMP: begin y = ~b_i; cin = 1'b1; end
      OP_RSB:         begin x = b_i; y = ~a_i; cin = 1'b1; end
      OP_ADD, OP_CMN: cin = 1'b0;
      OP_ADC:         cin = carry_i;
      OP_SBC:         begin y = ~b_i; cin = carry_i; end
      OP_RSC:         begin x = b_i; y = ~a_i; cin = carry_i; end
      default:        arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {32'd0, cin};
  assign ovf = (x[31] == y[31]) && (sum[31] != x[31]);

  // Result select; logical ops keep V and take C from the shifter
  always_comb begin
    case (op_i)
      OP_AND, OP_TST: result_o = a_i & b_i;
      OP_EOR, OP_TEQ: result_o = a_i ^ b_i;
      OP_ORR:         result_o = a_i | b_i;
      OP_MOV:         result_o = b_i;
      OP_BIC:         result_o = a_i & ~b_i;
      OP_MVN:         result_o = ~b_i;
      default:        result_o = sum[31:0];
    endcase
    nzcv_o = {result_o[31], (result_o == 32'd0),
              arith ? sum[32] : shift_carry_i,
              arith ? ovf : overflow_i};
  end

endmodule

// File: rtl/arm_cpu.sv
// rtl/arm_cpu.sv - multi-cycle ARM-subset core with internal 256-byte RAM
module arm_cpu
  import arm_cpu_pkg::*;
(
  input logic Clock,
  input logic Clear,
  input logic Enable
);

  logic [31:0] regs_q [0:15];
  logic [3:0]  flags_q;
  logic [31:0] mar_q, mdr_q, ir_q;
  state_e      state;
  logic [31:0] mem_rdata;
  logic        mem_we;

  logic [31:0] rn_val, rm_val, rd_val;
  logic        cond_ok, is_dp, is_mem, is_br, dp_test, set_flags;
  logic [31:0] op2, alu_result, br_target, mem_addr;
  logic        shc;
  logic [3:0]  alu_nzcv;
  logic [32:0] sh_tmp;
  logic [4:0]  amt;
  logic        unused_addr_bits;

  // R15 as an operand reads instruction address + 8; PC already holds + 4 in EXEC
  assign rn_val = (ir_q[19:16] == 4'd15) ? regs_q[15] + 32'd4 : regs_q[ir_q[19:16]];
  assign rm_val = (ir_q[3:0]   == 4'd15) ? regs_q[15] + 32'd4 : regs_q[ir_q[3:0]];
  assign rd_val = (ir_q[15:12] == 4'd15) ? regs_q[15] + 32'd4 : regs_q[ir_q[15:12]];

  assign cond_ok   = cond_pass(ir_q[31:28], flags_q);
  assign is_dp     = (ir_q[27:26] == 2'b00) && (ir_q[25] || !ir_q[4]);
  assign is_mem    = (ir_q[27:26] == 2'b01) && !ir_q[25] && ir_q[24] && !ir_q[22] && !ir_q[21];
  assign is_br     = (ir_q[27:25] == 3'b101);
  assign dp_test   = (ir_q[24:23] == 2'b10);
  assign set_flags = ir_q[20] || dp_test;
  assign amt       = ir_q[11:7];

  assign br_target = regs_q[15] + 32'd4 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
  assign mem_addr  = ir_q[23] ? rn_val + {20'd0, ir_q[11:0]} : rn_val - {20'd0, ir_q[11:0]};
  assign mem_we    = (state == MEM) && !ir_q[20];
  assign unused_addr_bits = ^{mar_q[31:8], mar_q[1:0]};

  // Operand2 barrel shifter with carry-out
  always_comb begin
    op2    = rm_val;
    shc    = flags_q[1];
    sh_tmp = '0;
    if (ir_q[25]) begin
      op2 = ror32({24'd0, ir_q[7:0]}, {ir_q[11:8], 1'b0});
      if (ir_q[11:8] != 4'd0) shc = op2[31];
    end else begin
      case (ir_q[6:5])
        SH_LSL: if (amt != 5'd0) begin
          sh_tmp = {1'b0, rm_val} << amt;
          op2 = sh_tmp[31:0]; shc = sh_tmp[32];
        end
        SH_LSR: if (amt == 5'd0) begin
          op2 = 32'd0; shc = rm_val[31];
        end else begin
          sh_tmp = {rm_val, 1'b0} >> amt;
          op2 = sh_tmp[32:1]; shc = sh_tmp[0];
        end
        SH_ASR: if (amt == 5'd0) begin
          op2 = {32{rm_val[31]}}; shc = rm_val[31];
        end else begin
          sh_tmp = $signed({rm_val, 1'b0}) >>> amt;
          op2 = sh_tmp[32:1]; shc = sh_tmp[0];
        end
        default: if (amt == 5'd0) begin
          op2 = {flags_q[1], rm_val[31:1]}; shc = rm_val[0];
        end else begin
          op2 = ror32(rm_val, amt); shc = op2[31];
        end
      endcase
    end
  end

  arm_alu u_alu (
    .a_i           (rn_val),
    .b_i           (op2),
    .op_i          (ir_q[24:21]),
    .carry_i       (flags_q[1]),
    .shift_carry_i (shc),
    .overflow_i    (flags_q[0]),
    .result_o      (alu_result),
    .nzcv_o        (alu_nzcv)
  );

  if (1) begin : CU
    state_e CurrentState, next_state;

    // State register
    always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) CurrentState <= FETCH;
      else if (Enable) CurrentState <= next_state;
    end

    // Next-state sequencing
    always_comb begin
      next_state = CurrentState;
      case (CurrentState)
        FETCH:   next_state = LOAD_IR;
        LOAD_IR: next_state = EXEC;
        EXEC:    next_state = (cond_ok && is_mem) ? MEM : FETCH;
        MEM:     next_state = ir_q[20] ? WB : FETCH;
        default: next_state = FETCH;
      endcase
    end

    assign state = CurrentState;
  end

  if (1) begin : ram
    logic [7:0] Mem [0:255];
    logic [5:0] widx;

    assign widx      = mar_q[7:2];
    assign mem_rdata = {Mem[{widx, 2'd0}], Mem[{widx, 2'd1}], Mem[{widx, 2'd2}], Mem[{widx, 2'd3}]};

    // Big-endian word store; memory is not touched by reset
    always_ff @(posedge Clock) begin
      if (Enable && mem_we) begin
        Mem[{widx, 2'd0}] <= rd_val[31:24];
        Mem[{widx, 2'd1}] <= rd_val[23:16];
        Mem[{widx, 2'd2}] <= rd_val[15:8];
        Mem[{widx, 2'd3}] <= rd_val[7:0];
      end
    end
  end

  // Register file, flags and datapath latches advanced per state
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      flags_q <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
    end else if (Enable) begin
      case (state)
        FETCH: mar_q <= regs_q[15];
        LOAD_IR: begin
          ir_q       <= mem_rdata;
          regs_q[15] <= regs_q[15] + 32'd4;
        end
        EXEC: if (cond_ok) begin
          if (is_dp) begin
            if (!dp_test) regs_q[ir_q[15:12]] <= alu_result;
            if (set_flags) flags_q <= alu_nzcv;
          end else if (is_br) begin
            regs_q[15] <= br_target;
            if (ir_q[24]) regs_q[14] <= regs_q[15];
          end else if (is_mem) begin
            mar_q <= mem_addr;
          end
        end
        MEM: if (ir_q[20]) mdr_q <= mem_rdata;
        WB:  regs_q[ir_q[15:12]] <= mdr_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_cpu.sv
// tb/tb_arm_cpu.sv - scoreboard bench for the arm_cpu core
module tb_arm_cpu;
  import arm_cpu_pkg::*;

  logic Clock = 1'b0;
  logic Clear = 1'b0;
  logic Enable = 1'b1;

  arm_cpu dut (.Clock(Clock), .Clear(Clear), .Enable(Enable));

  always #5 Clock = ~Clock;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  localparam int K_REG = 0, K_FLAGS = 1, K_STATE = 2, K_MEM = 3, K_MAR = 4, K_IR = 5, K_MDR = 6;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic expect_at(input int cyc, input int kind, input int idx,
                           input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.idx = idx; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      K_REG:   return dut.regs_q[idx];
      K_FLAGS: return {28'd0, dut.flags_q};
      K_STATE: return 32'(dut.CU.CurrentState);
      K_MEM:   return {dut.ram.Mem[idx], dut.ram.Mem[idx+1], dut.ram.Mem[idx+2], dut.ram.Mem[idx+3]};
      K_MAR:   return dut.mar_q;
      K_IR:    return dut.ir_q;
      K_MDR:   return dut.mdr_q;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic begin_reset;
    Clear = 1'b0;
    Enable = 1'b1;
    sb.delete();
    for (int i = 0; i < 256; i++) dut.ram.Mem[i] = 8'h00;
    step(1);
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    dut.ram.Mem[a]   = w[31:24];
    dut.ram.Mem[a+1] = w[23:16];
    dut.ram.Mem[a+2] = w[15:8];
    dut.ram.Mem[a+3] = w[7:0];
  endtask

  task automatic test_reset;
    begin_reset();
    put_word(0, 32'hE3A01005);
    put_word(4, 32'hE2812003);
    Clear = 1'b1;
    step(5);
    #2 Clear = 1'b0;
    #1;
    expect_at(0, K_STATE, 0, 32'(FETCH), "rst_state_async");
    for (int i = 0; i < 16; i++) expect_at(0, K_REG, i, 32'd0, $sformatf("rst_r%0d", i));
    expect_at(0, K_FLAGS, 0, 32'd0, "rst_flags");
    expect_at(0, K_IR, 0, 32'd0, "rst_ir");
    expect_at(0, K_MAR, 0, 32'd0, "rst_mar");
    expect_at(1, K_STATE, 0, 32'(FETCH), "rst_state_held");
    expect_at(1, K_REG, 15, 32'd0, "rst_pc_held");
    expect_at(2, K_STATE, 0, 32'(LOAD_IR), "first_fetch_state");
    expect_at(2, K_MAR, 0, 32'd0, "first_fetch_mar");
    expect_at(3, K_IR, 0, 32'hE3A01005, "first_ir");
    expect_at(3, K_REG, 15, 32'd4, "first_pc");
    for (int c = 0; c <= 3; c++) begin
      if (c == 2) Clear = 1'b1;
      if (c > 0) step(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = observe(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", e.name, c, got, e.exp);
        end
      end
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s: not reached", e.name);
    end
  endtask

  task automatic test_dp;
    begin_reset();
    put_word(0, 32'hE3A01005);
    put_word(4, 32'hE2812003);
    expect_at(3, K_REG, 1, 32'd5, "mov_r1");
    expect_at(3, K_REG, 2, 32'd0, "add_r2_early");
    expect_at(3, K_REG, 15, 32'd4, "dp_pc4");
    expect_at(6, K_REG, 2, 32'd8, "add_r2");
    expect_at(6, K_REG, 15, 32'd8, "dp_pc8");
    Clear = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = observe(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", e.name, c, got, e.exp);
        end
      end
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s: not reached", e.name);
    end
  endtask

  task automatic test_alu;
    logic [31:0] prog [11];
    prog = '{32'hE3A01005, 32'hE0513001, 32'h13A04001, 32'hE3A094FF, 32'hE1A08201, 32'hE3510006,
             32'hE3E06000, 32'hE2967001, 32'hE3A0A102, 32'hE25AB001, 32'hF3A0C001};
    begin_reset();
    for (int i = 0; i < 11; i++) put_word(4 * i, prog[i]);
    expect_at(6,  K_REG, 3, 32'd0, "subs_r3");
    expect_at(6,  K_FLAGS, 0, 32'h6, "subs_flags");
    expect_at(9,  K_REG, 4, 32'd0, "movne_skipped");
    expect_at(9,  K_REG, 15, 32'd12, "movne_pc");
    expect_at(9,  K_STATE, 0, 32'(FETCH), "movne_state");
    expect_at(12, K_REG, 9, 32'hFF000000, "mov_rot_imm");
    expect_at(15, K_REG, 8, 32'h50, "mov_lsl4");
    expect_at(18, K_FLAGS, 0, 32'h8, "cmp_flags");
    expect_at(18, K_REG, 0, 32'd0, "cmp_no_rd");
    expect_at(21, K_REG, 6, 32'hFFFFFFFF, "mvn_r6");
    expect_at(21, K_FLAGS, 0, 32'h8, "mvn_flags_kept");
    expect_at(24, K_REG, 7, 32'd0, "adds_wrap_r7");
    expect_at(24, K_FLAGS, 0, 32'h6, "adds_flags");
    expect_at(27, K_REG, 10, 32'h80000000, "mov_r10");
    expect_at(30, K_REG, 11, 32'h7FFFFFFF, "subs_ovf_r11");
    expect_at(30, K_FLAGS, 0, 32'h3, "subs_ovf_flags");
    expect_at(33, K_REG, 12, 32'd0, "nv_skipped");
    expect_at(33, K_REG, 15, 32'd44, "alu_pc");
    Clear = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      step(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = observe(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", e.name, c, got, e.exp);
        end
      end
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s: not reached", e.name);
    end
  endtask

  task automatic test_mem;
    begin_reset();
    put_word(0,  32'hE3A02008);
    put_word(4,  32'hE5802040);
    put_word(8,  32'hE5905040);
    put_word(12, 32'hE3A03C01);
    put_word(16, 32'hE5832048);
    put_word(20, 32'hE51360B8);
    expect_at(6,  K_STATE, 0, 32'(MEM), "str_mem_state");
    expect_at(6,  K_MAR, 0, 32'd64, "str_mar");
    expect_at(6,  K_MEM, 64, 32'd0, "str_not_yet");
    expect_at(7,  K_MEM, 64, 32'h00000008, "str_word64");
    expect_at(7,  K_STATE, 0, 32'(FETCH), "str_done_state");
    expect_at(7,  K_REG, 15, 32'd8, "str_pc");
    expect_at(11, K_STATE, 0, 32'(WB), "ldr_wb_state");
    expect_at(11, K_REG, 5, 32'd0, "ldr_r5_early");
    expect_at(12, K_REG, 5, 32'd8, "ldr_r5");
    expect_at(12, K_STATE, 0, 32'(FETCH), "ldr_done_state");
    expect_at(15, K_REG, 3, 32'h100, "mov_r3_100");
    expect_at(19, K_MEM, 72, 32'h00000008, "str_wrap_word72");
    expect_at(23, K_REG, 6, 32'd0, "ldr_sub_early");
    expect_at(24, K_REG, 6, 32'd8, "ldr_sub_r6");
    expect_at(24, K_REG, 15, 32'd24, "mem_pc");
    Clear = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = observe(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", e.name, c, got, e.exp);
        end
      end
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s: not reached", e.name);
    end
  endtask

  task automatic test_branch;
    begin_reset();
    put_word(0,  32'hEB000001);
    put_word(12, 32'hEAFFFFFE);
    expect_at(3, K_REG, 15, 32'd12, "bl_pc");
    expect_at(3, K_REG, 14, 32'd4, "bl_lr");
    expect_at(5, K_REG, 15, 32'd16, "b_pc_inc");
    expect_at(6, K_REG, 15, 32'd12, "b_loop1");
    expect_at(6, K_STATE, 0, 32'(FETCH), "b_state");
    expect_at(8, K_REG, 15, 32'd16, "b_pc_inc2");
    expect_at(9, K_REG, 15, 32'd12, "b_loop2");
    expect_at(9, K_REG, 14, 32'd4, "b_lr_kept");
    Clear = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = observe(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", e.name, c, got, e.exp);
        end
      end
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s: not reached", e.name);
    end
  endtask

  task automatic test_stall;
    int tag;
    begin_reset();
    put_word(0, 32'hE3A02008);
    put_word(4, 32'hE5802040);
    put_word(8, 32'hE5905040);
    expect_at(10,   K_STATE, 0, 32'(MEM), "stall_pre_state");
    expect_at(10,   K_MAR, 0, 32'd64, "stall_pre_mar");
    expect_at(1000, K_STATE, 0, 32'(MEM), "stall_state_frozen");
    expect_at(1000, K_REG, 5, 32'd0, "stall_r5_frozen");
    expect_at(1000, K_MDR, 0, 32'd0, "stall_mdr_frozen");
    expect_at(1000, K_REG, 15, 32'd12, "stall_pc_frozen");
    expect_at(1000, K_MEM, 64, 32'h00000008, "stall_mem_frozen");
    expect_at(11,   K_STATE, 0, 32'(WB), "stall_wb_state");
    expect_at(11,   K_MDR, 0, 32'd8, "stall_mdr");
    expect_at(12,   K_REG, 5, 32'd8, "stall_r5");
    expect_at(12,   K_STATE, 0, 32'(FETCH), "stall_done_state");
    expect_at(12,   K_REG, 15, 32'd12, "stall_pc");
    Clear = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      if (c == 11) begin
        Enable = 1'b0;
        step(4);
        tag = 1000;
        Enable = 1'b1;
      end else begin
        step(1);
        tag = (c > 11) ? c - 1 : c;
      end
      while (sb.size() > 0 && sb[0].cyc == tag) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = observe(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s tag %0d: got %h expected %h", e.name, tag, got, e.exp);
        end
      end
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s: not reached", e.name);
    end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_alu();
    test_mem();
    test_branch();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
